// File: rtl/ps2_pkg.sv
// ps2_pkg: frame constants, receiver state encoding and parity helper shared by the PS/2 blocks
package ps2_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: generic first-word-fall-through FIFO; a push while full is taken only alongside a pop
module ps2_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign valid   = cnt != '0;
  assign full    = cnt == (AW+1)'(FIFO_DEPTH);
  assign dout    = mem[rp];
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_push);
      rp  <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ps2_rx_checked.sv
// ps2_rx_checked: PS/2 device-to-host receiver with glitch filter, frame checks, timeout and output FIFO
module ps2_rx_checked import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2c,
  input  logic                 ps2d,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 err_timeout,
  output logic                 overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic [1:0] c_sy, d_sy;
  logic [FILTER_LEN-1:0] shr;
  logic filt, filt_n, fall, d_in;
  logic [FRAME_BITS-2:0] sh;
  logic [3:0] bcnt;
  logic [TW-1:0] tcnt;
  logic timeout, is_chk, stop_bad, par_bad, good, push, pop, full;
  // Synchronisers and filter idle high so reset release never looks like a falling edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      c_sy <= '1;
      d_sy <= '1;
      shr  <= '1;
      filt <= 1'b1;
    end else begin
      c_sy <= {c_sy[0], ps2c};
      d_sy <= {d_sy[0], ps2d};
      shr  <= {shr[FILTER_LEN-2:0], c_sy[1]};
      filt <= filt_n;
    end
  assign filt_n  = &shr ? 1'b1 : |shr ? filt : 1'b0;
  assign fall    = filt & ~filt_n;
  assign d_in    = d_sy[1];
  assign timeout = state == RX && !fall && tcnt == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall && rx_en && !d_in ? RX : IDLE;
      RX:      state_n = timeout ? IDLE : fall && bcnt == 4'(FRAME_BITS-2) ? CHECK : RX;
      default: state_n = IDLE;
    endcase
  end
  // Shift register fills LSB-first: sh[7:0] data, sh[8] parity, sh[9] stop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sh   <= '0;
      bcnt <= '0;
      tcnt <= '0;
    end else if (state != RX) begin
      bcnt <= '0;
      tcnt <= '0;
    end else if (fall) begin
      sh   <= {d_in, sh[FRAME_BITS-2:1]};
      bcnt <= bcnt + 4'd1;
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  always_comb begin
    is_chk   = state == CHECK;
    stop_bad = ~sh[FRAME_BITS-2];
    par_bad  = sh[DATA_BITS] != odd_parity(sh[DATA_BITS-1:0]);
    good     = is_chk & ~stop_bad & ~par_bad;
    push     = good & (~full | pop);
  end
  assign pop = rx_valid & rx_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      err_frame   <= is_chk & stop_bad;
      err_parity  <= is_chk & ~stop_bad & par_bad;
      err_timeout <= timeout;
      overflow    <= good & full & ~pop;
    end
  ps2_rx_fifo #(.WIDTH(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (sh[DATA_BITS-1:0]),
    .pop   (pop),
    .dout  (rx_data),
    .valid (rx_valid),
    .full  (full)
  );
endmodule

// File: tb/tb_ps2_rx_checked.sv
// tb_ps2_rx_checked: randomized PS/2 frames checked against a queue-based model of the received byte stream
module tb_ps2_rx_checked;
  localparam int FL = 8, TO = 300, FD = 4, H = 25;
  localparam int EV_NONE = 0, EV_GOOD = 1, EV_PAR = 2, EV_FRAME = 3, EV_TO = 4, EV_OVF = 5;
  logic clk = 0, reset = 1, ps2c = 1, ps2d = 1, rx_en = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, err_parity, err_frame, err_timeout, overflow;
  int n_tests = 0, n_fail = 0;
  int exp_evt = EV_NONE, seen = 0;
  bit settled = 1, rnd_ready = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  ps2_rx_checked #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout), .overflow(overflow)
  );

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic odd(input logic [7:0] d);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(d[i]);
    return (c % 2) == 0;
  endfunction

  always @(negedge clk) if (!reset) begin
    int np, code;
    np = int'(err_parity) + int'(err_frame) + int'(err_timeout) + int'(overflow);
    if (np != 0) begin
      code = err_parity ? EV_PAR : err_frame ? EV_FRAME : err_timeout ? EV_TO : EV_OVF;
      chk("pulse_count", np, 1);
      chk("pulse_kind", code, exp_evt);
      seen++;
    end
    if (settled) begin
      chk("valid", int'(rx_valid), int'(q.size() != 0));
      if (rx_valid && q.size() != 0) begin
        chk("data", int'(rx_data), int'(q[0]));
        if (rx_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) rx_ready = settled && ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_bit(input logic b, input int g);
    ps2d = b;
    repeat (12) tick();
    if (g > 0) begin
      ps2c = 0;
      repeat (g) tick();
      ps2c = 1;
    end
    repeat (H - 12 - g) tick();
    ps2c = 0;
    repeat (H) tick();
    ps2c = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbad, input logic sbad,
                            input int g, input bit off_mid, input bit en_off);
    logic [10:0] f;
    int e;
    f = {~sbad, odd(d) ^ pbad, d, 1'b0};
    if (en_off) rx_en = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(f[i], g);
      if (i == 0 && off_mid) rx_en = 0;
    end
    rx_ready = 0;
    settled = 0;
    tick();
    tick();
    e = en_off ? EV_NONE : sbad ? EV_FRAME : pbad ? EV_PAR : (q.size() == FD) ? EV_OVF : EV_GOOD;
    exp_evt = e;
    seen = 0;
    send_bit(f[10], g);
    repeat (40) tick();
    chk("event_seen", seen, int'(e >= EV_PAR));
    if (e == EV_GOOD) q.push_back(d);
    exp_evt = EV_NONE;
    settled = 1;
    rx_en = 1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int n);
    logic [10:0] f;
    f = {1'b1, odd(d), d, 1'b0};
    exp_evt = EV_TO;
    seen = 0;
    for (int i = 0; i < n; i++) send_bit(f[i], 0);
    ps2d = 1;
    repeat (TO + 100) tick();
    chk("timeout_seen", seen, 1);
    exp_evt = EV_NONE;
  endtask

  task automatic pop1();
    rx_ready = 1;
    tick();
    rx_ready = 0;
    tick();
  endtask

  initial begin
    logic [10:0] f;
    repeat (5) tick();
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_errs", int'({err_parity, err_frame, err_timeout, overflow}), 0);
    reset = 0;
    repeat (20) tick();
    send_frame(8'h1C, 0, 0, 0, 0, 0);
    chk("lit_1c_valid", int'(rx_valid), 1);
    chk("lit_1c_data", int'(rx_data), 'h1C);
    pop1();
    chk("lit_1c_popped", int'(rx_valid), 0);
    send_frame(8'h1C, 1, 0, 0, 0, 0);
    chk("lit_par_empty", int'(rx_valid), 0);
    send_frame(8'hF0, 0, 0, 0, 0, 0);
    chk("lit_f0_data", int'(rx_data), 'hF0);
    pop1();
    send_frame(8'h5A, 0, 0, 3, 0, 0);
    chk("lit_5a_glitch", int'(rx_data), 'h5A);
    pop1();
    send_partial(8'h29, 5);
    send_frame(8'h29, 0, 0, 0, 0, 0);
    chk("lit_29_after_to", int'(rx_data), 'h29);
    pop1();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("lit_fifo_order", int'(rx_data), k);
      pop1();
    end
    chk("lit_fifo_drained", int'(rx_valid), 0);
    f = {1'b1, odd(8'h44), 8'h44, 1'b0};
    for (int i = 0; i < 6; i++) send_bit(f[i], 0);
    ps2d = 1;
    reset = 1;
    settled = 0;
    tick();
    tick();
    q.delete();
    chk("midreset_valid", int'(rx_valid), 0);
    chk("midreset_errs", int'({err_parity, err_frame, err_timeout, overflow}), 0);
    reset = 0;
    repeat (20) tick();
    settled = 1;
    send_frame(8'h76, 0, 0, 0, 0, 0);
    chk("lit_76_data", int'(rx_data), 'h76);
    pop1();
    send_frame(8'hAA, 0, 1, 0, 0, 0);
    chk("lit_frame_empty", int'(rx_valid), 0);
    send_frame(8'h55, 0, 0, 0, 0, 1);
    chk("lit_disabled_empty", int'(rx_valid), 0);
    send_frame(8'h33, 0, 0, 0, 1, 0);
    chk("lit_en_mid_off", int'(rx_data), 'h33);
    pop1();
    rnd_ready = 1;
    for (int n = 0; n < 28; n++) begin
      if ($urandom_range(0, 9) == 0)
        send_partial(8'($urandom), $urandom_range(1, 10));
      else
        send_frame(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 2) == 0 ? $urandom_range(1, 6) : 0, 0, 0);
    end
    rnd_ready = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) pop1();
    chk("final_model_empty", q.size(), 0);
    chk("final_valid", int'(rx_valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_checked.md
Name: ps2_rx_checked

Overview:
Parametrised PS/2 device-to-host receiver, the next generation of the keyboard front end.
- Synchronises and glitch-filters ps2c/ps2d, deframes 11-bit frames and checks start, odd parity and stop bits.
- Aborts stalled frames on an inter-edge timeout.
- Buffers good bytes in a small FIFO with a valid/ready interface, so the C64 keyboard-matrix logic can back-pressure.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised ps2c samples needed to change the filtered clock (2..16)
TIMEOUT_CYCLES, 2000, clk cycles allowed between falling edges inside a frame before abort (must be > 1)
FIFO_DEPTH, 4, output FIFO entries, power of two >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2c  in  1  raw PS/2 clock line
ps2d  in  1  raw PS/2 data line
rx_en  in  1  enable; gates only the start of new frames
rx_data  out  8  head byte of FIFO, LSB = first data bit received
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head byte when rx_valid & rx_ready
err_parity  out  1  one-cycle pulse: frame with bad parity dropped
err_frame  out  1  one-cycle pulse: frame with stop bit = 0 dropped
err_timeout  out  1  one-cycle pulse: frame aborted by timeout
overflow  out  1  one-cycle pulse: good byte dropped, FIFO full

Behaviour:
- Reset values: all outputs 0, filtered clock = 1, state IDLE, FIFO empty, all counters 0.
- Input sync: ps2c and ps2d each pass through a 2-flop synchroniser. ps2d is sampled from its synchronised copy.
- Filter: a FILTER_LEN-bit shift register of synchronised ps2c.
  - All ones sets the filtered clock to 1; all zeros sets it to 0; any other pattern holds it.
  - fall = (filtered clock 1 -> 0), a single-cycle strobe.
- States:
  - IDLE -> RX on fall & rx_en & sampled ps2d == 0 (valid start bit).
  - fall with ps2d == 1 in IDLE is ignored.
  - RX: on each fall, shift ps2d into a 10-bit register (8 data, parity, stop, LSB first) and increment the bit counter 0..10.
  - RX -> CHECK when the counter reaches 10. CHECK lasts exactly one cycle, then -> IDLE.
- CHECK evaluation:
  - Stop bit = 0 -> err_frame. This takes priority over parity.
  - Otherwise, XOR of 8 data bits and the parity bit == 0 -> err_parity.
  - Otherwise, byte good: push into FIFO, or pulse overflow if the FIFO is full and no pop occurs in this cycle.
- Timeout:
  - The cycle counter clears on entering RX and on every fall while in RX.
  - If it reaches TIMEOUT_CYCLES-1 with no fall, pulse err_timeout, discard partial data and go to IDLE.
  - The timeout counter is inactive in IDLE and CHECK.
- rx_en deasserted mid-frame does not abort; the frame completes and is checked normally.
- FIFO behaviour:
  - First-word-fall-through; rx_data is valid whenever rx_valid = 1.
  - Push and pop in the same cycle are both performed. Push while full with simultaneous pop is accepted.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- Latency: a good byte appears on rx_data/rx_valid one clk after the CHECK cycle. The CHECK cycle is the cycle after the 11th fall.
- Error pulses are mutually exclusive per frame. At most one error or overflow pulse occurs per frame.
- Asynchronous reset at any point, mid-frame included, discards all state immediately.

Decomposition:
- Shared package ps2_pkg:
  - frame constants FRAME_BITS = 11 and DATA_BITS = 8;
  - state encoding (IDLE, RX, CHECK);
  - a function computing odd parity over 8 bits.
- One sub-module: ps2_rx_fifo, a generic synchronous FWFT FIFO parametrised by width and FIFO_DEPTH, reused by the later ps2 transmit path.
- Synchroniser, filter and FSM stay in ps2_rx_checked.

Test Plan:
- Send byte 0x1C with odd parity bit 0 and stop 1, rx_en = 1, rx_ready = 0 -> rx_valid = 1, rx_data = 0x1C, no error pulses. Raise rx_ready for 1 cycle -> rx_valid = 0.
- Send 0x1C with parity bit 1 -> err_parity pulses exactly once, rx_valid stays 0. Then send 0xF0 with correct parity -> rx_data = 0xF0.
- FILTER_LEN = 8; inject 3-cycle low glitches on ps2c between real edges -> no extra bits shifted, 0x5A received correctly.
- Send start plus 4 bits, then hold ps2c high for TIMEOUT_CYCLES -> err_timeout pulses once, state returns to IDLE. A following full 0x29 frame is received correctly.
- FIFO_DEPTH = 4, rx_ready = 0; send 0x01..0x05 -> overflow pulses on the 5th byte. Popping returns 0x01, 0x02, 0x03, 0x04 in order, then rx_valid = 0.
- Assert reset mid-frame after 6 falls, release, send 0x76 -> rx_data = 0x76, no errors. Stop bit 0 on the next frame -> err_frame only.
